// File: rtl/audio_pkg.sv
// Shared audio constants: note code layout, octave-0 half-period table at 50 MHz, FSM states.
package audio_pkg;

    localparam int unsigned NOTE_W              = 7;
    localparam int unsigned OCT_MSB             = 6;
    localparam int unsigned OCT_LSB             = 4;
    localparam int unsigned REST_NOTE           = 12;
    localparam int unsigned HALF_W              = 21;
    localparam int unsigned TABLE_CLK_HZ        = 50000000;
    localparam int unsigned DEFAULT_NOTE_CYCLES = 12500000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } ntp_state_t;

    // Octave-0 half period in clk cycles; rest codes return 0.
    function automatic logic [HALF_W-1:0] base_half(input logic [3:0] note);
        logic [HALF_W-1:0] h;
        case (note)
            4'd0:    h = HALF_W'(1529052);
            4'd1:    h = HALF_W'(1443238);
            4'd2:    h = HALF_W'(1362231);
            4'd3:    h = HALF_W'(1285766);
            4'd4:    h = HALF_W'(1213592);
            4'd5:    h = HALF_W'(1145475);
            4'd6:    h = HALF_W'(1081175);
            4'd7:    h = HALF_W'(1020484);
            4'd8:    h = HALF_W'(963206);
            4'd9:    h = HALF_W'(909091);
            4'd10:   h = HALF_W'(858069);
            4'd11:   h = HALF_W'(809848);
            default: h = '0;
        endcase
        return h;
    endfunction

    function automatic logic is_rest(input logic [3:0] note);
        return note >= 4'(REST_NOTE);
    endfunction

endpackage

// File: rtl/square_wave_gen.sv
// Half-period counter and phase flip-flop; loads the octave-shifted half period on i_load.
module square_wave_gen
    import audio_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_load,
    input  logic              i_run,
    input  logic [NOTE_W-1:0] i_note_code,
    output logic              o_phase,
    output logic              o_toggle_c
);

    logic [HALF_W-1:0] r_half;
    logic [HALF_W-1:0] r_tone_cnt;
    logic              r_phase;
    logic [HALF_W-1:0] w_base;

    assign w_base     = base_half(i_note_code[3:0]);
    assign o_toggle_c = i_run && (r_tone_cnt == r_half - HALF_W'(1));
    assign o_phase    = r_phase;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_half     <= '0;
            r_tone_cnt <= '0;
            r_phase    <= 1'b0;
        end else if (i_load) begin
            r_half     <= w_base >> i_note_code[OCT_MSB:OCT_LSB];
            r_tone_cnt <= '0;
            r_phase    <= 1'b0;
        end else if (i_run) begin
            if (o_toggle_c) begin
                r_tone_cnt <= '0;
                r_phase    <= ~r_phase;
            end else begin
                r_tone_cnt <= r_tone_cnt + HALF_W'(1);
            end
        end
    end

endmodule

// File: rtl/note_tone_player.sv
// Plays one note per request as a square-wave sample stream and pulses note_done on completion.
// Optional decaying envelope when NOTE_ENVELOPE_EN is defined.
module note_tone_player
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned NOTE_CYCLES = DEFAULT_NOTE_CYCLES,
    parameter int unsigned AMPLITUDE   = 10000000,
    parameter int unsigned SAMPLE_W    = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       note_en,
    input  logic [NOTE_W-1:0]          note_code,
    output logic                       note_done,
    output logic                       busy,
    input  logic                       audio_out_allowed,
    output logic                       write_audio_out,
    output logic signed [SAMPLE_W-1:0] sample
);

    localparam int unsigned         DUR_W   = $clog2(NOTE_CYCLES);
    localparam logic [SAMPLE_W-1:0] AMP_POS = SAMPLE_W'(AMPLITUDE);

    // The half-period table is only valid for its design clock.
    if (CLK_HZ != TABLE_CLK_HZ) begin : g_clk_chk
        $error("note_tone_player: BASE_HALF table assumes a 50 MHz clock");
    end
    if (NOTE_CYCLES < 4) begin : g_dur_chk
        $error("note_tone_player: NOTE_CYCLES must be at least 4");
    end

    ntp_state_t                 r_state;
    logic                       r_rest;
    logic [DUR_W-1:0]           r_dur;
    logic                       r_done;
    logic                       r_busy;
    logic signed [SAMPLE_W-1:0] r_sample;

    logic                       w_load;
    logic                       w_run;
    logic                       w_phase;
    logic                       w_toggle;
    logic [DUR_W-1:0]           w_dur_next;
    logic [SAMPLE_W-1:0]        w_mag;
    logic [SAMPLE_W-1:0]        w_level;

    assign w_load = (r_state == ST_IDLE) && note_en;
    assign w_run  = (r_state == ST_PLAY) && !r_rest;

    square_wave_gen u_wave (
        .clk         (clk),
        .resetn      (resetn),
        .i_load      (w_load),
        .i_run       (w_run),
        .i_note_code (note_code),
        .o_phase     (w_phase),
        .o_toggle_c  (w_toggle)
    );

`ifdef NOTE_ENVELOPE_EN
    // Quarter boundaries: q = floor(4*d/NOTE_CYCLES) steps at d = ceil(j*NOTE_CYCLES/4).
    localparam longint unsigned Q1_T = (longint'(NOTE_CYCLES) + 3) / 4;
    localparam longint unsigned Q2_T = (2 * longint'(NOTE_CYCLES) + 3) / 4;
    localparam longint unsigned Q3_T = (3 * longint'(NOTE_CYCLES) + 3) / 4;
`endif

    // Level for the sample that appears together with the next phase/duration values.
    always_comb begin
        w_dur_next = r_dur + DUR_W'(1);
        w_mag      = AMP_POS;
`ifdef NOTE_ENVELOPE_EN
        if (w_dur_next >= DUR_W'(Q3_T)) begin
            w_mag = AMP_POS >> 3;
        end else if (w_dur_next >= DUR_W'(Q2_T)) begin
            w_mag = AMP_POS >> 2;
        end else if (w_dur_next >= DUR_W'(Q1_T)) begin
            w_mag = AMP_POS >> 1;
        end
`endif
        w_level = (w_phase ^ w_toggle) ? (-w_mag) : w_mag;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_rest   <= 1'b0;
            r_dur    <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_sample <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_dur    <= '0;
                    r_sample <= '0;
                    if (note_en) begin
                        r_state  <= ST_PLAY;
                        r_rest   <= is_rest(note_code[3:0]);
                        r_busy   <= 1'b1;
                        r_sample <= is_rest(note_code[3:0]) ? '0 : AMP_POS;
                    end
                end
                ST_PLAY: begin
                    if (!note_en) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_dur    <= '0;
                        r_sample <= '0;
                    end else if (r_dur == DUR_W'(NOTE_CYCLES - 1)) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_sample <= '0;
                    end else begin
                        r_dur    <= w_dur_next;
                        r_sample <= r_rest ? '0 : w_level;
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_dur    <= '0;
                    r_sample <= '0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_sample <= '0;
                end
            endcase
        end
    end

    assign write_audio_out = audio_out_allowed;
    assign note_done       = r_done;
    assign busy            = r_busy;
    assign sample          = r_sample;

endmodule
